// File: rtl/upcounter_ctl_if.sv
// Handshake/status bundle for upcounter_ctl.
// UPCNT_OVF_STICKY_EN adds the sticky-overflow pair ovf/ovf_clr.
interface upcounter_ctl_if #(parameter int WIDTH = 4);
  logic             start;
  logic             stop;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             oneshot;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic             done;
`ifdef UPCNT_OVF_STICKY_EN
  logic             ovf_clr;
  logic             ovf;
`endif

  modport master (
    output start, stop, load, load_val, en, oneshot,
`ifdef UPCNT_OVF_STICKY_EN
    output ovf_clr,
    input  ovf,
`endif
    input  count, tc, busy, done
  );

  modport slave (
    input  start, stop, load, load_val, en, oneshot,
`ifdef UPCNT_OVF_STICKY_EN
    input  ovf_clr,
    output ovf,
`endif
    output count, tc, busy, done
  );
endinterface

// File: rtl/upcounter_ctl.sv
// Controlled up counter 0..MAX with IDLE/RUN/DONE gating, terminal-count pulse
// and busy/done status. UPCNT_OVF_STICKY_EN adds a sticky wrap flag (ovf).
module upcounter_ctl #(
  parameter int WIDTH = 4,
  parameter int MAX   = (2**WIDTH)-1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  upcounter_ctl_if.slave bus
);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_count, w_count_nxt, w_load_clamped;
  logic             r_tc, w_tc_nxt;
`ifdef UPCNT_OVF_STICKY_EN
  logic             r_ovf, w_wrap, w_restart;
`endif

  assign w_load_clamped = (bus.load_val > MAXV) ? MAXV : bus.load_val;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_tc    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_tc    <= w_tc_nxt;
    end
  end

  // Priority: load > stop > start > en-increment.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_tc_nxt    = 1'b0;
`ifdef UPCNT_OVF_STICKY_EN
    w_wrap      = 1'b0;
    w_restart   = 1'b0;
`endif
    if (bus.load) begin
      w_count_nxt = w_load_clamped;
      if (r_state == S_DONE) w_state_nxt = S_IDLE;
    end else if (bus.stop) begin
      w_state_nxt = S_IDLE;
    end else if (bus.start && r_state != S_RUN) begin
      w_state_nxt = S_RUN;
      if (r_state == S_DONE) w_count_nxt = '0;
`ifdef UPCNT_OVF_STICKY_EN
      w_restart   = 1'b1;
`endif
    end else if (r_state == S_RUN && bus.en) begin
      if (r_count == MAXV) begin
        w_tc_nxt = 1'b1;
        if (bus.oneshot) begin
          w_state_nxt = S_DONE;
        end else begin
          w_count_nxt = '0;
`ifdef UPCNT_OVF_STICKY_EN
          w_wrap      = 1'b1;
`endif
        end
      end else begin
        w_count_nxt = r_count + WIDTH'(1);
      end
    end
  end

`ifdef UPCNT_OVF_STICKY_EN
  // A wrap in the same cycle as a clear request leaves the flag set.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                    r_ovf <= 1'b0;
    else if (w_wrap)                 r_ovf <= 1'b1;
    else if (bus.ovf_clr || w_restart) r_ovf <= 1'b0;
  end
  assign bus.ovf = r_ovf;
`endif

  assign bus.count = r_count;
  assign bus.tc    = r_tc;
  assign bus.busy  = (r_state == S_RUN);
  assign bus.done  = (r_state == S_DONE);
endmodule

// File: tb/tb_upcounter_ctl.sv
// Scoreboard bench for upcounter_ctl: MAX=15 main instance, MAX=9 clamp/wrap
// instance, MAX=3 instance for the sticky overflow build.
module tb_upcounter_ctl;
  typedef struct packed {
    logic [3:0] cnt;
    logic       tc;
    logic       busy;
    logic       done;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  upcounter_ctl_if #(.WIDTH(4)) bus15();
  upcounter_ctl_if #(.WIDTH(4)) bus9();
  upcounter_ctl_if #(.WIDTH(4)) bus3();

  upcounter_ctl #(.WIDTH(4), .MAX(15)) u15 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus15.slave));
  upcounter_ctl #(.WIDTH(4), .MAX(9))  u9  (.i_clk(clk), .i_rst_n(rst_n), .bus(bus9.slave));
  upcounter_ctl #(.WIDTH(4), .MAX(3))  u3  (.i_clk(clk), .i_rst_n(rst_n), .bus(bus3.slave));

  function automatic exp_t obs15();
    return '{bus15.count, bus15.tc, bus15.busy, bus15.done, 1'b0};
  endfunction
  function automatic exp_t obs9();
    return '{bus9.count, bus9.tc, bus9.busy, bus9.done, 1'b0};
  endfunction
  function automatic exp_t obs3();
`ifdef UPCNT_OVF_STICKY_EN
    return '{bus3.count, bus3.tc, bus3.busy, bus3.done, bus3.ovf};
`else
    return '{bus3.count, bus3.tc, bus3.busy, bus3.done, 1'b0};
`endif
  endfunction

  function automatic exp_t mk(int c, bit t, bit b, bit d, bit o = 1'b0);
    return '{4'(c), t, b, d, o};
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic drv15(bit st, bit sp, bit ld, int lv, bit en, bit os);
    bus15.start = st; bus15.stop = sp; bus15.load = ld;
    bus15.load_val = 4'(lv); bus15.en = en; bus15.oneshot = os;
  endtask
  task automatic drv9(bit st, bit sp, bit ld, int lv, bit en, bit os);
    bus9.start = st; bus9.stop = sp; bus9.load = ld;
    bus9.load_val = 4'(lv); bus9.en = en; bus9.oneshot = os;
  endtask
  task automatic drv3(bit st, bit sp, bit ld, int lv, bit en, bit os);
    bus3.start = st; bus3.stop = sp; bus3.load = ld;
    bus3.load_val = 4'(lv); bus3.en = en; bus3.oneshot = os;
  endtask

  task automatic test_reset();
    exp_t e, got;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drv15(1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(15)), 1'($urandom), 1'($urandom));
      drv9 (1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(15)), 1'($urandom), 1'($urandom));
      q.push_back(mk(0, 0, 0, 0));
      cyc();
      e = q.pop_front(); got = obs15(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL reset15[%0d] got=%h exp=%h", i, got, e); end
      got = obs9(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL reset9[%0d] got=%h exp=%h", i, got, e); end
    end
    drv15(0, 0, 0, 0, 0, 0);
    drv9(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  // start (en low), 17 enabled cycles with oneshot=0, then stop
  task automatic test_wrap();
    exp_t e, got;
    drv15(1, 0, 0, 0, 0, 0); q.push_back(mk(0, 0, 1, 0));
    cyc(); e = q.pop_front(); got = obs15(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL wrap_start got=%h exp=%h", got, e); end
    for (int i = 1; i <= 17; i++) begin
      drv15(0, 0, 0, 0, 1, 0);
      q.push_back(mk(i % 16, i == 16, 1, 0));
      cyc(); e = q.pop_front(); got = obs15(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL wrap[%0d] got=%h exp=%h", i, got, e); end
    end
    drv15(0, 1, 0, 0, 0, 0); q.push_back(mk(1, 0, 0, 0));
    cyc(); e = q.pop_front(); got = obs15(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL wrap_stop got=%h exp=%h", got, e); end
  endtask

  // load 0 in IDLE, start with en high, run oneshot to DONE, restart, stop
  task automatic test_oneshot();
    exp_t e, got;
    drv15(0, 0, 1, 0, 0, 1); q.push_back(mk(0, 0, 0, 0));
    drv15(0, 0, 1, 0, 0, 1); cyc();
    e = q.pop_front(); got = obs15(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL os_load got=%h exp=%h", got, e); end
    drv15(1, 0, 0, 0, 1, 1); q.push_back(mk(0, 0, 1, 0));
    cyc(); e = q.pop_front(); got = obs15(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL os_start got=%h exp=%h", got, e); end
    for (int i = 1; i <= 20; i++) begin
      drv15(0, 0, 0, 0, 1, 1);
      if (i < 16) q.push_back(mk(i, 0, 1, 0));
      else        q.push_back(mk(15, i == 16, 0, 1));
      cyc(); e = q.pop_front(); got = obs15(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL oneshot[%0d] got=%h exp=%h", i, got, e); end
    end
    drv15(1, 0, 0, 0, 0, 1); q.push_back(mk(0, 0, 1, 0));
    cyc(); e = q.pop_front(); got = obs15(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL os_restart got=%h exp=%h", got, e); end
    drv15(0, 1, 0, 0, 0, 0); q.push_back(mk(0, 0, 0, 0));
    cyc(); e = q.pop_front(); got = obs15(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL os_stop got=%h exp=%h", got, e); end
  endtask

  task automatic test_load();
    exp_t e, got;
    drv15(1, 0, 0, 0, 0, 0); q.push_back(mk(0, 0, 1, 0));
    for (int i = 1; i <= 5; i++) q.push_back(mk(i, 0, 1, 0));
    q.push_back(mk(12, 0, 1, 0));
    q.push_back(mk(13, 0, 1, 0));
    for (int i = 0; i < 8; i++) begin
      if (i == 0)      drv15(1, 0, 0, 0, 0, 0);
      else if (i == 6) drv15(0, 0, 1, 12, 1, 0);
      else             drv15(0, 0, 0, 0, 1, 0);
      cyc(); e = q.pop_front(); got = obs15(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL load15[%0d] got=%h exp=%h", i, got, e); end
    end
    drv15(0, 1, 0, 0, 0, 0); cyc();
    // MAX=9 instance: clamp, exact load, then run across the terminal step
    q.push_back(mk(9, 0, 0, 0));
    q.push_back(mk(7, 0, 0, 0));
    q.push_back(mk(7, 0, 1, 0));
    q.push_back(mk(8, 0, 1, 0));
    q.push_back(mk(9, 0, 1, 0));
    q.push_back(mk(0, 1, 1, 0));
    q.push_back(mk(1, 0, 1, 0));
    for (int i = 0; i < 7; i++) begin
      case (i)
        0:       drv9(0, 0, 1, 14, 0, 0);
        1:       drv9(0, 0, 1, 7, 0, 0);
        2:       drv9(1, 0, 0, 0, 0, 0);
        default: drv9(0, 0, 0, 0, 1, 0);
      endcase
      cyc(); e = q.pop_front(); got = obs9(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL load9[%0d] got=%h exp=%h", i, got, e); end
    end
    drv9(0, 1, 0, 0, 0, 0); cyc();
  endtask

  // hold with en=0, stop beats start, reset mid-run gives no tc
  task automatic test_hold_stop_reset();
    exp_t e, got;
    q.push_back(mk(7, 0, 0, 0));
    q.push_back(mk(7, 0, 1, 0));
    for (int i = 0; i < 3; i++) q.push_back(mk(7, 0, 1, 0));
    q.push_back(mk(7, 0, 0, 0));
    q.push_back(mk(7, 0, 1, 0));
    q.push_back(mk(0, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0));
    for (int i = 0; i < 9; i++) begin
      rst_n = 1'b1;
      case (i)
        0:       drv15(0, 0, 1, 7, 0, 0);
        1:       drv15(1, 0, 0, 0, 0, 0);
        5:       drv15(1, 1, 0, 0, 1, 0);
        6:       drv15(1, 0, 0, 0, 0, 0);
        7:       begin drv15(0, 0, 0, 0, 1, 0); rst_n = 1'b0; end
        default: drv15(0, 0, 0, 0, 0, 0);
      endcase
      cyc(); e = q.pop_front(); got = obs15(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL hold[%0d] got=%h exp=%h", i, got, e); end
    end
    rst_n = 1'b1;
  endtask

`ifdef UPCNT_OVF_STICKY_EN
  task automatic test_ovf();
    exp_t e, got;
    bus3.ovf_clr = 1'b0;
    drv3(1, 0, 0, 0, 0, 0); q.push_back(mk(0, 0, 1, 0, 0));
    q.push_back(mk(1, 0, 1, 0, 0));
    q.push_back(mk(2, 0, 1, 0, 0));
    q.push_back(mk(3, 0, 1, 0, 0));
    q.push_back(mk(0, 1, 1, 0, 1));
    q.push_back(mk(1, 0, 1, 0, 1));
    q.push_back(mk(2, 0, 1, 0, 1));
    q.push_back(mk(3, 0, 1, 0, 1));
    q.push_back(mk(3, 0, 1, 0, 0));
    q.push_back(mk(0, 1, 1, 0, 1));
    q.push_back(mk(0, 0, 0, 0, 1));
    q.push_back(mk(0, 0, 1, 0, 0));
    for (int i = 0; i < 12; i++) begin
      bus3.ovf_clr = 1'b0;
      case (i)
        0:       drv3(1, 0, 0, 0, 0, 0);
        8:       begin drv3(0, 0, 0, 0, 0, 0); bus3.ovf_clr = 1'b1; end
        9:       begin drv3(0, 0, 0, 0, 1, 0); bus3.ovf_clr = 1'b1; end
        10:      drv3(0, 1, 0, 0, 0, 0);
        11:      drv3(1, 0, 0, 0, 0, 0);
        default: drv3(0, 0, 0, 0, 1, 0);
      endcase
      cyc(); e = q.pop_front(); got = obs3(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL ovf[%0d] got=%h exp=%h", i, got, e); end
    end
    bus3.ovf_clr = 1'b0;
    drv3(0, 1, 0, 0, 0, 0); cyc();
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    drv15(0, 0, 0, 0, 0, 0);
    drv9(0, 0, 0, 0, 0, 0);
    drv3(0, 0, 0, 0, 0, 0);
`ifdef UPCNT_OVF_STICKY_EN
    bus3.ovf_clr = 1'b0;
`endif
    test_reset();
    test_wrap();
    test_oneshot();
    test_load();
    test_hold_stop_reset();
`ifdef UPCNT_OVF_STICKY_EN
    test_ovf();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
